// File: rtl/machine_ctl.sv
// Instruction-cycle sequencer: locks to the fetch strobe, steps phases 0..7 and
// issues registered PC/ACC/IR/memory/bus strobes decoded from opcode and zero flag.
module machine_ctl #(
  parameter int OPW    = 3,
  parameter bit RESYNC = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           fetch,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  output logic           inc_pc,
  output logic           load_acc,
  output logic           load_pc,
  output logic           rd,
  output logic           wr,
  output logic           load_ir,
  output logic           datactl_ena,
  output logic           halt,
  output logic           sync_err,
  output logic           active
);

  localparam logic [OPW-1:0] OP_HLT  = OPW'(0);
  localparam logic [OPW-1:0] OP_SKZ  = OPW'(1);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(2);
  localparam logic [OPW-1:0] OP_ANDD = OPW'(3);
  localparam logic [OPW-1:0] OP_XORR = OPW'(4);
  localparam logic [OPW-1:0] OP_LDA  = OPW'(5);
  localparam logic [OPW-1:0] OP_STO  = OPW'(6);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(7);

  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

  typedef struct packed {
    logic inc_pc;
    logic load_acc;
    logic load_pc;
    logic rd;
    logic wr;
    logic load_ir;
    logic datactl_ena;
    logic halt;
  } strobe_t;

  state_t  state, state_n;
  logic [2:0] phase, phase_n, np;
  logic    fetch_q, rise;
  strobe_t strb, strb_n;
  logic    sync_err_n, active_n;

  function automatic strobe_t dec(input logic [2:0] p, input logic [OPW-1:0] op,
                                  input logic z);
    strobe_t s;
    logic    alu;
    s   = '0;
    alu = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    case (p)
      3'd0: begin s.rd = 1'b1; s.load_ir = 1'b1; end
      3'd1: begin s.inc_pc = 1'b1; s.rd = 1'b1; s.load_ir = 1'b1; end
      3'd3: begin s.inc_pc = 1'b1; s.halt = (op == OP_HLT); end
      3'd4: begin
        s.load_pc     = (op == OP_JMP);
        s.rd          = alu;
        s.datactl_ena = (op == OP_STO);
      end
      3'd5: begin
        s.load_acc    = alu;
        s.rd          = alu;
        s.inc_pc      = ((op == OP_SKZ) && z) || (op == OP_JMP);
        s.load_pc     = (op == OP_JMP);
        s.wr          = (op == OP_STO);
        s.datactl_ena = (op == OP_STO);
      end
      3'd6: begin s.rd = alu; s.datactl_ena = (op == OP_STO); end
      3'd7: s.inc_pc = (op == OP_SKZ) && z;
      default: s = '0;
    endcase
    return s;
  endfunction

  assign rise = fetch & ~fetch_q;
  assign np   = (rise && RESYNC) ? 3'd0 : phase + 3'd1;

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_n    = state;
    phase_n    = phase;
    strb_n     = '0;
    sync_err_n = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = RUN;
        phase_n = 3'd0;
        strb_n  = dec(3'd0, opcode, zero);
      end
      RUN: begin
        phase_n    = np;
        strb_n     = dec(np, opcode, zero);
        sync_err_n = rise && (phase != 3'd7);
        if ((np == 3'd3) && (opcode == OP_HLT)) state_n = HALTED;
      end
      HALTED: strb_n.halt = 1'b1;  // phase frozen, fetch ignored until reset
      default: state_n = IDLE;
    endcase
    active_n = (state_n == RUN);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      phase    <= 3'd0;
      fetch_q  <= 1'b0;
      strb     <= '0;
      sync_err <= 1'b0;
      active   <= 1'b0;
    end else begin
      state    <= state_n;
      phase    <= phase_n;
      fetch_q  <= fetch;
      strb     <= strb_n;
      sync_err <= sync_err_n;
      active   <= active_n;
    end
  end

  assign inc_pc      = strb.inc_pc;
  assign load_acc    = strb.load_acc;
  assign load_pc     = strb.load_pc;
  assign rd          = strb.rd;
  assign wr          = strb.wr;
  assign load_ir     = strb.load_ir;
  assign datactl_ena = strb.datactl_ena;
  assign halt        = strb.halt;

endmodule
